// File: rtl/os_drain_collector.sv
// Receive end of an output-stationary MAC column: shifts ROWS results out of the array,
// narrows each to OUT_W and streams them through a show-ahead FIFO with a last marker.
module os_drain_collector #(
  parameter int WIDTH_MAC  = 48,
  parameter int ROWS       = 4,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int SAT_EN     = 1,
  parameter int SIGNED     = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          reg_clear,
  input  logic                          start,
  input  logic [WIDTH_MAC-1:0]          mac_in,
  output logic                          drain_en,
  output logic                          busy,
  output logic                          done,
  output logic [OUT_W-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          sat_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [WIDTH_MAC-1:0] U_MAX = {WIDTH_MAC{1'b1}} >> (WIDTH_MAC - OUT_W);
  localparam logic [WIDTH_MAC-1:0] S_MAX = U_MAX >> 1;
  localparam logic [WIDTH_MAC-1:0] S_MIN = ~S_MAX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_r;
  logic [1:0]     state_nxt_s;
  logic [RW-1:0]  row_r;
  logic [OUT_W:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [CW-1:0]  count_r;
  logic           sat_r;
  logic           push_s;
  logic           pop_s;
  logic [OUT_W:0] head_s;
  logic [OUT_W:0] conv_s;

  // Returns {clamped, narrowed word}; bounds collapse to no-ops when OUT_W == WIDTH_MAC.
  function automatic logic [OUT_W:0] narrow(input logic [WIDTH_MAC-1:0] w);
    logic [OUT_W:0] r;
    r = {1'b0, w[OUT_W-1:0]};
    if (SAT_EN != 0) begin
      if (SIGNED != 0) begin
        if ($signed(w) > $signed(S_MAX)) begin
          r = {1'b1, S_MAX[OUT_W-1:0]};
        end else if ($signed(w) < $signed(S_MIN)) begin
          r = {1'b1, S_MIN[OUT_W-1:0]};
        end else begin
          r = {1'b0, w[OUT_W-1:0]};
        end
      end else if (w > U_MAX) begin
        r = {1'b1, U_MAX[OUT_W-1:0]};
      end else begin
        r = {1'b0, w[OUT_W-1:0]};
      end
    end else begin
      r = {1'b0, w[OUT_W-1:0]};
    end
    return r;
  endfunction

  assign out_valid  = (count_r != CW'(0));
  assign head_s     = mem_r[rd_ptr_r];
  assign out_data   = out_valid ? head_s[OUT_W-1:0] : {OUT_W{1'b0}};
  assign out_last   = out_valid ? head_s[OUT_W] : 1'b0;
  assign fifo_count = count_r;
  assign sat_flag   = sat_r;
  assign busy       = (state_r == S_DRAIN) || (state_r == S_FLUSH);
  assign done       = (state_r == S_DONE);
  assign pop_s      = out_valid && out_ready;
  // A full FIFO may still accept a word when the head leaves on the same edge.
  assign drain_en   = (state_r == S_DRAIN) && !reg_clear && ((count_r < DEPTH_C) || pop_s);
  assign push_s     = drain_en;

  // Word conversion for the capture edge
  always_comb begin
    conv_s = narrow(mac_in);
  end

  // Drain sequencing
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_DRAIN;
        else       state_nxt_s = S_IDLE;
      end
      S_DRAIN: begin
        if (push_s && (row_r == LAST_ROW)) state_nxt_s = S_FLUSH;
        else                               state_nxt_s = S_DRAIN;
      end
      S_FLUSH: begin
        if (pop_s && head_s[OUT_W]) state_nxt_s = S_DONE;
        else                        state_nxt_s = S_FLUSH;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, row counter, FIFO pointers/occupancy and sticky clamp flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      row_r    <= RW'(0);
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      sat_r    <= 1'b0;
    end else if (reg_clear) begin
      state_r  <= S_IDLE;
      row_r    <= RW'(0);
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      sat_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        row_r    <= (row_r == LAST_ROW) ? RW'(0) : row_r + RW'(1);
        sat_r    <= sat_r | conv_s[OUT_W];
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; the head is masked by out_valid so no reset is needed here
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {(row_r == LAST_ROW), conv_s[OUT_W-1:0]};
    end
  end

endmodule

// File: tb/tb_os_drain_collector.sv
// Bench for os_drain_collector: three parameterisations share stimulus; each has its own
// column feeder and a queue-level reference checked every cycle, plus literal spot checks.
module tb_os_drain_collector;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic reg_clear = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  // instance 0: defaults; 1: signed saturating 16b, depth 2; 2: truncating 16b, depth 2
  int depth  [N] = '{8, 2, 2};
  int ow     [N] = '{32, 16, 16};
  bit sat_en [N] = '{1'b1, 1'b1, 1'b0};
  bit sgn    [N] = '{1'b0, 1'b1, 1'b0};

  logic [47:0] col [N][4];
  int          ptr [N];
  bit          ptr_rst = 1'b0;
  logic [47:0] mac_a, mac_b, mac_c;

  logic de_a, de_b, de_c, bz_a, bz_b, bz_c, dn_a, dn_b, dn_c;
  logic ov_a, ov_b, ov_c, ol_a, ol_b, ol_c, sf_a, sf_b, sf_c;
  logic [31:0] od_a;
  logic [15:0] od_b, od_c;
  logic [3:0]  fc_a;
  logic [1:0]  fc_b, fc_c;

  logic [N-1:0] de, bz, dn, ov, ol, sf;
  logic [47:0]  od [N];
  logic [3:0]   fc [N];

  assign de = {de_c, de_b, de_a};
  assign bz = {bz_c, bz_b, bz_a};
  assign dn = {dn_c, dn_b, dn_a};
  assign ov = {ov_c, ov_b, ov_a};
  assign ol = {ol_c, ol_b, ol_a};
  assign sf = {sf_c, sf_b, sf_a};
  assign od[0] = {16'd0, od_a};
  assign od[1] = {32'd0, od_b};
  assign od[2] = {32'd0, od_c};
  assign fc[0] = fc_a;
  assign fc[1] = {2'd0, fc_b};
  assign fc[2] = {2'd0, fc_c};

  always_comb begin
    mac_a = (ptr[0] < 4) ? col[0][ptr[0]] : 48'd0;
    mac_b = (ptr[1] < 4) ? col[1][ptr[1]] : 48'd0;
    mac_c = (ptr[2] < 4) ? col[2][ptr[2]] : 48'd0;
  end

  os_drain_collector u_a (
    .clk(clk), .rst_n(rst_n), .reg_clear(reg_clear), .start(start), .mac_in(mac_a),
    .drain_en(de_a), .busy(bz_a), .done(dn_a), .out_data(od_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_last(ol_a), .sat_flag(sf_a), .fifo_count(fc_a));

  os_drain_collector #(.OUT_W(16), .FIFO_DEPTH(2), .SAT_EN(1), .SIGNED(1)) u_b (
    .clk(clk), .rst_n(rst_n), .reg_clear(reg_clear), .start(start), .mac_in(mac_b),
    .drain_en(de_b), .busy(bz_b), .done(dn_b), .out_data(od_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_last(ol_b), .sat_flag(sf_b), .fifo_count(fc_b));

  os_drain_collector #(.OUT_W(16), .FIFO_DEPTH(2), .SAT_EN(0), .SIGNED(0)) u_c (
    .clk(clk), .rst_n(rst_n), .reg_clear(reg_clear), .start(start), .mac_in(mac_c),
    .drain_en(de_c), .busy(bz_c), .done(dn_c), .out_data(od_c), .out_valid(ov_c),
    .out_ready(out_ready), .out_last(ol_c), .sat_flag(sf_c), .fifo_count(fc_c));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: expected FIFO contents as a shift array, plus drain phase flags.
  logic [48:0] mq [N][8];
  int mcnt [N];
  int m_row [N];
  bit m_dr [N], m_fl [N], m_dn [N], m_sat [N];

  function automatic logic [48:0] model_conv(input logic [47:0] w, input int i);
    longint v, lo, hi, mask;
    bit f;
    mask = (longint'(1) << ow[i]) - 1;
    if (sgn[i]) v = longint'($signed(w));
    else        v = longint'({16'd0, w});
    f = 1'b0;
    if (sat_en[i]) begin
      lo = sgn[i] ? -(longint'(1) << (ow[i] - 1)) : 0;
      hi = sgn[i] ? (longint'(1) << (ow[i] - 1)) - 1 : mask;
      if (v > hi) begin v = hi; f = 1'b1; end
      else if (v < lo) begin v = lo; f = 1'b1; end
    end
    return {f, 48'(v & mask)};
  endfunction

  function automatic logic [47:0] macv(input int i);
    return (ptr[i] < 4) ? col[i][ptr[i]] : 48'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_blk
    logic [48:0] tq [8];
    logic [48:0] cv;
    int tc, trow;
    bit tdr, tfl, tdn, tsat, pop, plast, push;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mcnt[i] <= 0; m_row[i] <= 0; m_dr[i] <= 1'b0; m_fl[i] <= 1'b0;
        m_dn[i] <= 1'b0; m_sat[i] <= 1'b0; ptr[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 8; k++) tq[k] = mq[i][k];
        tc = mcnt[i]; trow = m_row[i];
        tdr = m_dr[i]; tfl = m_fl[i]; tdn = 1'b0; tsat = m_sat[i];
        push = 1'b0;
        if (reg_clear) begin
          tc = 0; trow = 0; tdr = 1'b0; tfl = 1'b0; tsat = 1'b0;
        end else begin
          pop = (tc != 0) && out_ready;
          plast = pop && tq[0][48];
          push = tdr && ((tc < depth[i]) || pop);
          if (pop) begin
            for (int k = 0; k < 7; k++) tq[k] = tq[k + 1];
            tc--;
          end
          if (push) begin
            cv = model_conv(macv(i), i);
            tq[tc] = {(trow == 3), cv[47:0]};
            tsat = tsat | cv[48];
            tc++;
            if (trow == 3) begin tdr = 1'b0; tfl = 1'b1; trow = 0; end
            else trow++;
          end
          if (m_fl[i] && plast) begin tfl = 1'b0; tdn = 1'b1; end
          if (!m_dr[i] && !m_fl[i] && !m_dn[i] && start) begin tdr = 1'b1; trow = 0; end
        end
        for (int k = 0; k < 8; k++) mq[i][k] <= tq[k];
        mcnt[i] <= tc; m_row[i] <= trow; m_dr[i] <= tdr; m_fl[i] <= tfl;
        m_dn[i] <= tdn; m_sat[i] <= tsat;
        if (ptr_rst) ptr[i] <= 0;
        else if (push) ptr[i] <= ptr[i] + 1;
      end
    end
  end

  logic [47:0] rd [N][8];
  logic        rl [N][8];
  int rcnt [N];
  int de_hi [N];
  int dn_hi [N];

  // Per-cycle comparison against the reference, plus recording of popped words
  always @(negedge clk) begin
    bit v;
    for (int i = 0; i < N; i++) begin
      v = (mcnt[i] != 0);
      chk($sformatf("drain_en[%0d]", i), 48'(de[i]),
          48'(m_dr[i] && !reg_clear && ((mcnt[i] < depth[i]) || (v && out_ready))));
      chk($sformatf("busy[%0d]", i), 48'(bz[i]), 48'(m_dr[i] || m_fl[i]));
      chk($sformatf("done[%0d]", i), 48'(dn[i]), 48'(m_dn[i]));
      chk($sformatf("out_valid[%0d]", i), 48'(ov[i]), 48'(v));
      chk($sformatf("out_data[%0d]", i), od[i], v ? mq[i][0][47:0] : 48'd0);
      chk($sformatf("out_last[%0d]", i), 48'(ol[i]), 48'(v && mq[i][0][48]));
      chk($sformatf("sat_flag[%0d]", i), 48'(sf[i]), 48'(m_sat[i]));
      chk($sformatf("fifo_count[%0d]", i), 48'(fc[i]), 48'(mcnt[i]));
      if (ov[i] && out_ready && rst_n && !reg_clear && rcnt[i] < 8) begin
        rd[i][rcnt[i]] = od[i];
        rl[i][rcnt[i]] = ol[i];
        rcnt[i]++;
      end
      de_hi[i] += int'(de[i]);
      dn_hi[i] += int'(dn[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [47:0] w0, input logic [47:0] w1,
                      input logic [47:0] w2, input logic [47:0] w3);
    for (int i = 0; i < N; i++) begin
      col[i][0] = w0; col[i][1] = w1; col[i][2] = w2; col[i][3] = w3;
    end
    ptr_rst = 1'b1;
    tick();
    ptr_rst = 1'b0;
  endtask

  task automatic clr_rec();
    for (int i = 0; i < N; i++) begin
      rcnt[i] = 0; de_hi[i] = 0; dn_hi[i] = 0;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int k;
    k = 0;
    while ((bz != 3'b000 || dn != 3'b000) && k < maxc) begin
      tick();
      k++;
    end
    if (k >= maxc) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, busy=%b", maxc, bz);
    end
  endtask

  initial begin
    logic [3:0] lb;
    #2;
    chk("reset busy", 48'(bz), 48'd0);
    chk("reset valid", 48'(ov), 48'd0);
    chk("reset count", 48'(fc[0]), 48'd0);
    chk("reset drain_en", 48'(de), 48'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // back-to-back drain
    out_ready = 1'b1;
    load(48'd10, 48'd20, 48'd30, 48'd40);
    clr_rec();
    pulse_start();
    wait_idle(40);
    chk("t1 drain cycles", 48'(de_hi[0]), 48'd4);
    chk("t1 pops", 48'(rcnt[0]), 48'd4);
    chk("t1 word0", rd[0][0], 48'd10);
    chk("t1 word1", rd[0][1], 48'd20);
    chk("t1 word2", rd[0][2], 48'd30);
    chk("t1 word3", rd[0][3], 48'd40);
    lb = {rl[0][3], rl[0][2], rl[0][1], rl[0][0]};
    chk("t1 last flags", 48'(lb), 48'h8);
    chk("t1 done pulses", 48'(dn_hi[0]), 48'd1);
    chk("t1 depth2 word3", rd[1][3], 48'd40);

    // truncation vs saturation of the same word
    load(48'h0000_0012_3456, 48'd1, 48'd2, 48'd3);
    clr_rec();
    pulse_start();
    wait_idle(40);
    chk("t4 trunc word", rd[2][0], 48'h3456);
    chk("t4 trunc flag", 48'(sf[2]), 48'd0);
    chk("t4 sat word", rd[1][0], 48'h7FFF);
    chk("t4 sat flag", 48'(sf[1]), 48'd1);
    chk("t4 wide word", rd[0][0], 48'h12_3456);
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    chk("clear flags", 48'(sf), 48'd0);

    // signed saturation
    load(48'h0000_0001_0000, 48'hFFFF_FFFF_FFFE, 48'd5, 48'd6);
    clr_rec();
    pulse_start();
    wait_idle(40);
    chk("t3 pos clamp", rd[1][0], 48'h7FFF);
    chk("t3 neg keep", rd[1][1], 48'hFFFE);
    chk("t3 flag sticky", 48'(sf[1]), 48'd1);
    chk("t3 unsigned clamp", rd[0][1], 48'hFFFF_FFFF);
    chk("t3 trunc no flag", 48'(sf[2]), 48'd0);

    // backpressure
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    out_ready = 1'b0;
    load(48'd1, 48'd2, 48'd3, 48'd4);
    clr_rec();
    pulse_start();
    repeat (6) tick();
    chk("t2 depth2 drain cycles", 48'(de_hi[1]), 48'd2);
    chk("t2 depth2 count", 48'(fc[1]), 48'd2);
    chk("t2 depth2 stalled", 48'(de[1]), 48'd0);
    chk("t2 depth8 count", 48'(fc[0]), 48'd4);
    out_ready = 1'b1;
    wait_idle(40);
    chk("t2 pops", 48'(rcnt[1]), 48'd4);
    chk("t2 word0", rd[1][0], 48'd1);
    chk("t2 word2", rd[1][2], 48'd3);
    chk("t2 word3", rd[1][3], 48'd4);
    lb = {rl[1][3], rl[1][2], rl[1][1], rl[1][0]};
    chk("t2 last flags", 48'(lb), 48'h8);

    // abort after two captures
    out_ready = 1'b0;
    load(48'h1_0000_0000, 48'd8, 48'd9, 48'd10);
    clr_rec();
    pulse_start();
    tick(); tick();
    chk("t5 flag before clear", 48'(sf[0]), 48'd1);
    reg_clear = 1'b1;
    tick();
    reg_clear = 1'b0;
    chk("t5 busy", 48'(bz), 48'd0);
    chk("t5 valid", 48'(ov), 48'd0);
    chk("t5 flags", 48'(sf), 48'd0);
    chk("t5 count", 48'(fc[1]), 48'd0);
    out_ready = 1'b1;
    load(48'd11, 48'd12, 48'd13, 48'd14);
    clr_rec();
    pulse_start();
    wait_idle(40);
    chk("t5 restart pops", 48'(rcnt[1]), 48'd4);
    chk("t5 restart word0", rd[1][0], 48'd11);
    lb = {rl[1][3], rl[1][2], rl[1][1], rl[1][0]};
    chk("t5 restart last", 48'(lb), 48'h8);

    // start while busy, then async reset during flush
    out_ready = 1'b0;
    load(48'd1, 48'd2, 48'd3, 48'd4);
    clr_rec();
    pulse_start();
    tick();
    pulse_start();
    repeat (4) tick();
    chk("t6 captures", 48'(de_hi[0]), 48'd4);
    chk("t6 busy in flush", 48'(bz[0]), 48'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst busy", 48'(bz), 48'd0);
    chk("t6 rst valid", 48'(ov), 48'd0);
    chk("t6 rst count", 48'(fc[0]), 48'd0);
    chk("t6 rst data", od[0], 48'd0);
    chk("t6 rst drain", 48'(de), 48'd0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6 no done", 48'(dn_hi[0]), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
